// File: rtl/warmboot_ctrl.sv
// Button-driven warm-boot image selector for SB_WARMBOOT: short press steps the image, long press commits.
// Optional LED blink indicator is compiled in with `define WARMBOOT_LED_EN.
module warmboot_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES    = 240000,
   parameter int unsigned LONG_CYCLES        = 24000000,
   parameter int unsigned SEL_TIMEOUT_CYCLES = 120000000,
   parameter logic [1:0]  DEFAULT_IMAGE      = 2'd0,
   parameter int unsigned BLINK_CYCLES       = 2400000
) (
   input  logic       clk_24,
   input  logic       rst_24,
   input  logic       btn_n,
   output logic       boot,
   output logic [1:0] image,
   output logic       led
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
   localparam int TO_W   = $clog2(SEL_TIMEOUT_CYCLES + 1);
   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
   localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(SEL_TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, PRESS, SELECT, ARMED, BOOT} state_t;

   logic              sync_p0, sync_p1;
   logic              press;
   logic [DB_W-1:0]   db_cnt;
   logic              btn_db, btn_db_d;
   logic              rise, fall;
   state_t            state, state_nxt;
   logic [1:0]        sel, sel_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [TO_W-1:0]   to_cnt, to_nxt;
   logic              boot_q;

   // Synchroniser and debouncer; btn_db is the debounced "pressed" level
   assign press = ~sync_p1;
   assign rise  = btn_db & ~btn_db_d;
   assign fall  = ~btn_db & btn_db_d;

   always_ff @(posedge clk_24 or posedge rst_24) begin
      if (rst_24) begin
         sync_p0  <= 1'b1;
         sync_p1  <= 1'b1;
         db_cnt   <= '0;
         btn_db   <= 1'b0;
         btn_db_d <= 1'b0;
      end else begin
         sync_p0  <= btn_n;
         sync_p1  <= sync_p0;
         btn_db_d <= btn_db;
         if (press == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            btn_db <= press;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      hold_nxt  = hold_cnt;
      to_nxt    = to_cnt;
      case (state)
         IDLE: begin
            if (rise) begin
               state_nxt = PRESS;
               hold_nxt  = '0;
            end
         end
         PRESS: begin
            if (fall && hold_cnt != HOLD_MAX) begin
               sel_nxt   = sel + 2'd1;
               state_nxt = SELECT;
               to_nxt    = '0;
            end else if (hold_cnt == HOLD_MAX) begin
               state_nxt = ARMED;
            end else if (btn_db) begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         SELECT: begin
            // A new press on the expiry cycle keeps the pending selection
            if (rise) begin
               state_nxt = PRESS;
               hold_nxt  = '0;
            end else if (to_cnt == TO_MAX) begin
               sel_nxt   = DEFAULT_IMAGE;
               state_nxt = IDLE;
            end else begin
               to_nxt = to_cnt + TO_W'(1);
            end
         end
         ARMED: begin
            // Level test also covers a release coinciding with the long-press threshold
            if (!btn_db) state_nxt = BOOT;
         end
         BOOT:    state_nxt = BOOT;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_24 or posedge rst_24) begin
      if (rst_24) begin
         state    <= IDLE;
         sel      <= DEFAULT_IMAGE;
         hold_cnt <= '0;
         to_cnt   <= '0;
         boot_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         hold_cnt <= hold_nxt;
         to_cnt   <= to_nxt;
         boot_q   <= (state == BOOT);
      end
   end

   assign boot  = boot_q;
   assign image = sel;

`ifdef WARMBOOT_LED_EN
   localparam int BLK_W = $clog2(BLINK_CYCLES + 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);

   logic [BLK_W-1:0] tick_cnt, tick_nxt;
   logic [3:0]       slot, slot_nxt, slot_last;
   logic             blinking, led_nxt, led_q;

   // Pattern is a sequence of BLINK_CYCLES slots: sel+1 on/off pairs, then 8 off slots
   always_comb begin
      blinking  = (state_nxt == PRESS) || (state_nxt == SELECT);
      slot_last = {1'b0, sel_nxt, 1'b0} + 4'd9;
      tick_nxt  = '0;
      slot_nxt  = '0;
      if (blinking && (state == PRESS || state == SELECT) && sel_nxt == sel) begin
         if (tick_cnt == BLK_LAST) begin
            slot_nxt = (slot == slot_last) ? 4'd0 : slot + 4'd1;
         end else begin
            tick_nxt = tick_cnt + BLK_W'(1);
            slot_nxt = slot;
         end
      end
      led_nxt = (state_nxt == ARMED) || (state_nxt == BOOT) ||
                (blinking && !slot_nxt[0] && slot_nxt < ({1'b0, sel_nxt, 1'b0} + 4'd2));
   end

   always_ff @(posedge clk_24 or posedge rst_24) begin
      if (rst_24) begin
         tick_cnt <= '0;
         slot     <= '0;
         led_q    <= 1'b0;
      end else begin
         tick_cnt <= tick_nxt;
         slot     <= slot_nxt;
         led_q    <= led_nxt;
      end
   end

   assign led = led_q;
`else
   // Blink period only matters when the LED option is built in
   logic unused_blink;
   assign unused_blink = ^BLINK_CYCLES;
   assign led          = 1'b0;
`endif

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Scoreboard bench for warmboot_ctrl: expected image/boot events are queued when the button is driven.
module tb_warmboot_ctrl;

   localparam int DB       = 4;
   localparam int LONG     = 100;
   localparam int TMO      = 200;
   localparam int BLK      = 3;
   localparam int IMG_LAT  = 2 + DB + 1;
   localparam int BOOT_LAT = 2 + DB + 2;

   logic       clk_24;
   logic       rst_24;
   logic       btn_n;
   logic       boot;
   logic [1:0] image;
   logic       led;

   typedef struct {
      logic [1:0] val;
      int         cyc;
   } exp_t;

   exp_t       img_q[$];
   int         boot_q[$];
   exp_t       e_img;
   int         e_boot;
   int         cyc;
   int         n_chk;
   int         n_err;
   logic [1:0] last_img;
   logic       last_boot;
   int         led_hi;
   int         rel;

   warmboot_ctrl #(
      .DEBOUNCE_CYCLES   (DB),
      .LONG_CYCLES       (LONG),
      .SEL_TIMEOUT_CYCLES(TMO),
      .DEFAULT_IMAGE     (2'd0),
      .BLINK_CYCLES      (BLK)
   ) dut (
      .clk_24(clk_24),
      .rst_24(rst_24),
      .btn_n (btn_n),
      .boot  (boot),
      .image (image),
      .led   (led)
   );

   initial clk_24 = 1'b0;
   always #5 clk_24 = ~clk_24;

   initial cyc = 0;
   always @(posedge clk_24) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_24);
   endtask

   task automatic press(input int hold, input logic [1:0] exp_img, output int rel_cyc);
      exp_t t;
      btn_n = 1'b0;
      tick(hold);
      btn_n   = 1'b1;
      rel_cyc = cyc;
      t.val   = exp_img;
      t.cyc   = rel_cyc + IMG_LAT;
      img_q.push_back(t);
   endtask

   // Output monitor: every image change and boot rise must match the head of its queue
   initial begin
      last_img  = 2'd0;
      last_boot = 1'b0;
      led_hi    = 0;
   end

   always @(negedge clk_24) begin
      if (!rst_24 && image !== last_img) begin
         chk("img_expected", img_q.size() > 0, 1'b1);
         if (img_q.size() > 0) begin
            e_img = img_q.pop_front();
            chk("img_val", image, e_img.val);
            chk("img_cyc", cyc, e_img.cyc);
         end
      end
      if (!rst_24 && boot && !last_boot) begin
         chk("boot_expected", boot_q.size() > 0, 1'b1);
         if (boot_q.size() > 0) begin
            e_boot = boot_q.pop_front();
            chk("boot_cyc", cyc, e_boot);
         end
      end
      last_img  <= image;
      last_boot <= boot;
      if (led) led_hi <= led_hi + 1;
   end

   initial begin
      n_chk  = 0;
      n_err  = 0;
      rst_24 = 1'b1;
      btn_n  = 1'b1;
      tick(3);
      chk("rst_boot", boot, 1'b0);
      chk("rst_image", image, 2'd0);
      chk("rst_led", led, 1'b0);
      rst_24 = 1'b0;
      tick(3);

      // Glitch shorter than the debounce window
      btn_n = 1'b0;
      tick(3);
      btn_n = 1'b1;
      tick(20);
      chk("glitch_boot", boot, 1'b0);
      chk("glitch_image", image, 2'd0);
      chk("glitch_led", led, 1'b0);

      // Short presses step 1,2,3 and wrap to 0
      press(20, 2'd1, rel);
      tick(15);
      press(20, 2'd2, rel);
`ifdef WARMBOOT_LED_EN
      tick(IMG_LAT);
      for (int i = 0; i < 42; i++) begin
         chk("led_pat", led, (i < 18) && ((i % 6) < 3));
         tick(1);
      end
      chk("led_restart", led, 1'b1);
      tick(5);
`else
      tick(15);
`endif
      press(20, 2'd3, rel);
      tick(15);
      press(20, 2'd0, rel);
      tick(TMO + 30);
      chk("wrap_image", image, 2'd0);

      // Commit: short press then long hold
      press(20, 2'd1, rel);
      tick(15);
      btn_n = 1'b0;
      tick(130);
      chk("armed_boot", boot, 1'b0);
      chk("armed_image", image, 2'd1);
`ifdef WARMBOOT_LED_EN
      chk("armed_led", led, 1'b1);
`endif
      tick(20);
      btn_n = 1'b1;
      boot_q.push_back(cyc + BOOT_LAT);
      tick(20);
      chk("commit_boot", boot, 1'b1);
      chk("commit_image", image, 2'd1);
      btn_n = 1'b0;
      tick(20);
      btn_n = 1'b1;
      tick(20);
      chk("boot_hold", boot, 1'b1);
      chk("boot_image", image, 2'd1);
`ifdef WARMBOOT_LED_EN
      chk("boot_led", led, 1'b1);
`endif

      // Asynchronous reset in BOOT
      @(negedge clk_24);
      #2 rst_24 = 1'b1;
      #1;
      chk("rstboot_boot", boot, 1'b0);
      chk("rstboot_image", image, 2'd0);
      chk("rstboot_led", led, 1'b0);
      tick(3);
      rst_24 = 1'b0;
      tick(5);

      // Timeout reverts the selection
      press(20, 2'd1, rel);
      e_img.val = 2'd0;
      e_img.cyc = rel + IMG_LAT + TMO + 1;
      img_q.push_back(e_img);
      tick(IMG_LAT + TMO + 8);
      chk("tmo_image", image, 2'd0);

      // Press landing exactly on the expiry cycle keeps the selection
      press(20, 2'd1, rel);
      tick(IMG_LAT + TMO - (2 + DB));
      press(20, 2'd2, rel);
      tick(20);
      chk("tmo_race_image", image, 2'd2);

      // Asynchronous reset in ARMED, button still held
      btn_n = 1'b0;
      tick(130);
`ifdef WARMBOOT_LED_EN
      chk("armed2_led", led, 1'b1);
`endif
      #2 rst_24 = 1'b1;
      #1;
      chk("rstarm_boot", boot, 1'b0);
      chk("rstarm_image", image, 2'd0);
      btn_n = 1'b1;
      tick(3);
      rst_24 = 1'b0;
      tick(10);
      chk("post_rst_boot", boot, 1'b0);
      chk("post_rst_image", image, 2'd0);

      chk("img_q_left", img_q.size(), 0);
      chk("boot_q_left", boot_q.size(), 0);
`ifndef WARMBOOT_LED_EN
      chk("led_never_high", led_hi, 0);
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
